// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, access-type codes and byte-count helpers for the data memory
package dmem_pkg;

  typedef logic [31:0] word_t;

  localparam logic [2:0] DM_B  = 3'b000;
  localparam logic [2:0] DM_H  = 3'b001;
  localparam logic [2:0] DM_W  = 3'b010;
  localparam logic [2:0] DM_BU = 3'b100;
  localparam logic [2:0] DM_HU = 3'b101;

  // Bytes written by a store of the given type; 0 means the store is ignored.
  function automatic logic [2:0] store_bytes(input logic [2:0] t);
    case (t)
      DM_B:    return 3'd1;
      DM_H:    return 3'd2;
      DM_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] load_bytes(input logic [2:0] t);
    case (t)
      DM_B, DM_BU: return 3'd1;
      DM_H, DM_HU: return 3'd2;
      DM_W:        return 3'd4;
      default:     return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_data_memory_if.sv
// rtl/riscv_data_memory_if.sv - MEM-stage access bus between pipeline (master) and data memory (slave)
interface riscv_data_memory_if;
  import dmem_pkg::*;

  logic       store;
  word_t      direccion;
  word_t      offset;
  word_t      store_data;
  logic [2:0] Type;
  word_t      load_data;

  modport master (
    output store, direccion, offset, store_data, Type,
    input  load_data
  );

  modport slave (
    input  store, direccion, offset, store_data, Type,
    output load_data
  );

endinterface

// File: rtl/dmem_load_ext.sv
// rtl/dmem_load_ext.sv - assembles little-endian load bytes and applies sign/zero extension
module dmem_load_ext
  import dmem_pkg::*;
(
  input  word_t      raw_word,
  input  logic [2:0] type_code,
  output word_t      load_data
);

  always_comb begin
    load_data = '0;
    case (type_code)
      DM_B:    load_data = {{24{raw_word[7]}}, raw_word[7:0]};
      DM_H:    load_data = {{16{raw_word[15]}}, raw_word[15:0]};
      DM_W:    load_data = raw_word;
      DM_BU:   load_data = {24'b0, raw_word[7:0]};
      DM_HU:   load_data = {16'b0, raw_word[15:0]};
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/riscv_data_memory.sv
// rtl/riscv_data_memory.sv - byte-addressable little-endian data memory, 32*TAM bytes
// Optional DATA_MEMORY_BOUNDS_CHECK_EN: accesses running past the top are dropped instead of wrapping.
module riscv_data_memory
  import dmem_pkg::*;
#(
  parameter int TAM = 4
) (
  input logic                 clk,
  input logic                 rst,
  riscv_data_memory_if.slave  bus
);

  localparam int DEPTH = 32 * TAM;
  localparam int AW    = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  word_t         ea;
  logic [AW-1:0] idx [4];
  logic [2:0]    st_n;
  logic          st_oob;
  logic          ld_oob;
  word_t         raw_word;
  word_t         ext_data;

  assign ea   = bus.direccion + bus.offset;
  assign st_n = store_bytes(bus.Type);

  // Every byte lane wraps independently so misaligned accesses may straddle the top.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      idx[k] = AW'((ea + word_t'(k)) % word_t'(DEPTH));
    end
  end

`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
  function automatic logic past_end(input word_t a, input logic [2:0] n);
    logic [32:0] last;
    last = {1'b0, a} + 33'(n) - 33'd1;
    return (n != 3'd0) && (last >= 33'(DEPTH));
  endfunction

  assign st_oob = past_end(ea, st_n);
  assign ld_oob = past_end(ea, load_bytes(bus.Type));
`else
  assign st_oob = 1'b0;
  assign ld_oob = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (bus.store && !st_oob) begin
      for (int k = 0; k < 4; k++) begin
        if (k < int'(st_n)) begin
          mem[idx[k]] <= bus.store_data[8*k +: 8];
        end
      end
    end
  end

  assign raw_word = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};

  dmem_load_ext u_load_ext (
    .raw_word  (raw_word),
    .type_code (bus.Type),
    .load_data (ext_data)
  );

  assign bus.load_data = ld_oob ? '0 : ext_data;

endmodule

// File: tb/tb_riscv_data_memory.sv
// tb/tb_riscv_data_memory.sv - scoreboard bench for riscv_data_memory against a byte-array reference model
module tb_riscv_data_memory;
  import dmem_pkg::*;

  localparam int DEPTH = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  riscv_data_memory_if bus ();

  riscv_data_memory #(.TAM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    word_t exp;
    string name;
  } item_t;

  item_t sb[$];
  byte unsigned model_mem [DEPTH];
  int pass_cnt  = 0;
  int total_cnt = 0;

  function automatic int access_size(input logic [2:0] t, input bit is_store);
    if (is_store) return (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : (t == 3'd2) ? 4 : 0;
    return (t == 3'd0 || t == 3'd4) ? 1 : (t == 3'd1 || t == 3'd5) ? 2 : (t == 3'd2) ? 4 : 0;
  endfunction

  function automatic bit out_of_range(input word_t ea, input int n);
`ifdef DATA_MEMORY_BOUNDS_CHECK_EN
    return (n > 0) && (longint'(ea) + longint'(n) > longint'(DEPTH));
`else
    return 1'b0;
`endif
  endfunction

  function automatic word_t model_load(input word_t d, input word_t o, input logic [2:0] t);
    word_t ea;
    word_t a;
    int n;
    longint u;
    longint v;
    ea = d + o;
    n  = access_size(t, 1'b0);
    if (n == 0 || out_of_range(ea, n)) return 32'h0;
    u = 0;
    for (int k = 0; k < n; k++) begin
      a = ea + word_t'(k);
      u = u + longint'(model_mem[a % DEPTH]) * (longint'(1) << (8 * k));
    end
    v = u;
    if (t == 3'd0 && u >= 128)   v = u - 256;
    if (t == 3'd1 && u >= 32768) v = u - 65536;
    return word_t'(v);
  endfunction

  function automatic void model_store(input word_t d, input word_t o, input word_t sd, input logic [2:0] t);
    word_t ea;
    word_t a;
    int n;
    ea = d + o;
    n  = access_size(t, 1'b1);
    if (out_of_range(ea, n)) return;
    for (int k = 0; k < n; k++) begin
      a = ea + word_t'(k);
      model_mem[a % DEPTH] = byte'((sd >> (8 * k)) & 32'hFF);
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
  endfunction

  // One access per cycle: inputs settle after the edge, expectation is the pre-edge value.
  task automatic op(input logic st, input word_t d, input word_t o, input word_t sd,
                    input logic [2:0] t, input string nm);
    item_t it;
    @(posedge clk);
    #1;
    bus.store      = st;
    bus.direccion  = d;
    bus.offset     = o;
    bus.store_data = sd;
    bus.Type       = t;
    it.exp  = model_load(d, o, t);
    it.name = nm;
    sb.push_back(it);
    if (st && !rst) model_store(d, o, sd, t);
  endtask

  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        it = sb.pop_front();
        total_cnt++;
        if (bus.load_data === it.exp) pass_cnt++;
        else $display("FAIL %s: load_data=%08h expected %08h", it.name, bus.load_data, it.exp);
      end
    end
  end

  initial begin
    item_t it;
    logic st;
    logic [2:0] t;
    word_t d, o;

    model_clear();
    bus.store = 1'b0; bus.direccion = '0; bus.offset = '0; bus.store_data = '0; bus.Type = DM_W;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    op(0, 0, 0, 0, DM_W, "reset_lw0");
    for (int i = 0; i < DEPTH; i++) op(0, word_t'(i), 0, 0, DM_BU, "reset_byte");

    op(1, 0, 0, 32'h4000E081, DM_B, "sb_old");
    op(0, 0, 0, 0, DM_B,  "lb_81");
    op(0, 0, 0, 0, DM_BU, "lbu_81");
    for (int i = 0; i < 4; i++) op(0, word_t'(i), 0, 0, DM_BU, "sb_bytes");
    op(1, 0, 0, 32'h4000E081, DM_H, "sh");
    op(0, 0, 0, 0, DM_H,  "lh_e081");
    op(0, 0, 0, 0, DM_HU, "lhu_e081");
    op(1, 32'h0C, 0, 32'h4000E0FF, DM_W, "sw");
    op(0, 32'h0C, 0, 0, DM_W, "lw_0c");
    op(0, 32'h08, 4, 0, DM_B, "lb_8p4");
    for (int i = 12; i < 16; i++) op(0, word_t'(i), 0, 0, DM_BU, "sw_bytes");
    op(1, 0, 0, 32'hA5A5A5A5, 3'b011, "st_t011");
    op(0, 0, 0, 0, DM_W, "t011_nowrite");
    op(0, 0, 0, 0, 3'b011, "ld_t011");
    op(1, 126, 0, 32'h11223344, DM_W, "sw_wrap");
    op(0, 126, 0, 0, DM_W, "lw_wrap");
    op(0, 0, 0, 0, DM_W, "wrap_low");
    op(0, 32'hFFFFFFF0, 32'h8E, 0, DM_HU, "wrap_offset");

    for (int n = 0; n < 400; n++) begin
      st = 1'($urandom_range(0, 1));
      t  = 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 3) == 0) ? $urandom() : word_t'($urandom_range(0, 130));
      o  = ($urandom_range(0, 3) == 0) ? $urandom() : word_t'($urandom_range(0, 8));
      op(st, d, o, $urandom(), t, "random");
    end

    op(1, 8, 0, 32'hDEADBEEF, DM_W, "pre_rst");
    @(posedge clk);
    #3;
    rst = 1'b1;
    model_clear();
    bus.store = 1'b1; bus.direccion = 8; bus.offset = 0; bus.store_data = 32'hCAFEF00D; bus.Type = DM_W;
    it.exp = 32'h0; it.name = "rst_async";
    sb.push_back(it);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.store = 1'b0;
    it.exp = model_load(8, 0, DM_W); it.name = "rst_no_store";
    sb.push_back(it);
    for (int i = 0; i < DEPTH; i += 4) op(0, word_t'(i), 0, 0, DM_W, "post_rst");

    @(posedge clk);
    #1 bus.store = 1'b0;
    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      total_cnt++;
      $display("FAIL drain: pending=%0d expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
